// File: rtl/mem_arbiter.sv
// Shared-port arbiter: one instruction-fetch and one data requester share a
// single bus port; data wins unless fetch has been starved STARVE_LIM times.
module mem_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  output logic [31:0] iRdata,
  output logic        iValid,
  input  logic        dReq,
  input  logic        dWen,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [2:0]  dSize,
  output logic [31:0] dRdata,
  output logic        dValid,
  output logic        busReq,
  output logic        busWen,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [2:0]  busSize,
  input  logic        busGnt,
  input  logic        busRvalid,
  input  logic [31:0] busRdata,
  output logic        busErr
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [8:0]    TIMEOUT_9  = 9'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t        state_q, state_d;
  logic          sel_fetch_q, sel_fetch_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [8:0]    wait_q, wait_d;
  logic [8:0]    wait_inc;
  logic          grant_fetch;

  logic          bus_req_q, bus_req_d;
  logic          bus_wen_q, bus_wen_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [2:0]    bus_size_q, bus_size_d;
  logic          bus_err_q, bus_err_d;
  logic          i_valid_q, i_valid_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic          d_valid_q, d_valid_d;
  logic [31:0]   d_rdata_q, d_rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sel_fetch_q <= 1'b0;
      starve_q    <= '0;
      wait_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_wen_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_size_q  <= '0;
      bus_err_q   <= 1'b0;
      i_valid_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_fetch_q <= sel_fetch_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      bus_req_q   <= bus_req_d;
      bus_wen_q   <= bus_wen_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_size_q  <= bus_size_d;
      bus_err_q   <= bus_err_d;
      i_valid_q   <= i_valid_d;
      i_rdata_q   <= i_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Fetch only wins a contested slot once it has watched STARVE_LIM data grants.
  assign grant_fetch = iReq && (!dReq || (starve_q == STARVE_MAX));
  assign wait_inc    = wait_q + 9'd1;

  always_comb begin
    state_d     = state_q;
    sel_fetch_d = sel_fetch_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    bus_req_d   = bus_req_q;
    bus_wen_d   = bus_wen_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_size_d  = bus_size_q;
    bus_err_d   = 1'b0;
    i_valid_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (iReq || dReq) begin
          state_d   = ADDR;
          bus_req_d = 1'b1;
          if (grant_fetch) begin
            sel_fetch_d = 1'b1;
            bus_wen_d   = 1'b0;
            bus_addr_d  = iAddr;
            bus_wdata_d = '0;
            bus_size_d  = 3'b010;
            starve_d    = '0;
          end else begin
            sel_fetch_d = 1'b0;
            bus_wen_d   = dWen;
            bus_addr_d  = dAddr;
            bus_wdata_d = dWdata;
            bus_size_d  = dSize;
            if (!iReq)
              starve_d = '0;
            else if (starve_q != STARVE_MAX)
              starve_d = starve_q + SW'(1);
          end
        end
      end

      ADDR: begin
        if (busGnt) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
          wait_d    = '0;
        end
      end

      RESP: begin
        // A response on the timeout cycle still counts as a normal completion.
        if (busRvalid) begin
          state_d = IDLE;
          if (sel_fetch_q) begin
            i_valid_d = 1'b1;
            i_rdata_d = busRdata;
          end else begin
            d_valid_d = 1'b1;
            if (!bus_wen_q)
              d_rdata_d = busRdata;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_9) begin
            state_d   = IDLE;
            bus_err_d = 1'b1;
            if (sel_fetch_q) begin
              i_valid_d = 1'b1;
              i_rdata_d = '0;
            end else begin
              d_valid_d = 1'b1;
              d_rdata_d = '0;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busReq   = bus_req_q;
  assign busWen   = bus_wen_q;
  assign busAddr  = bus_addr_q;
  assign busWdata = bus_wdata_q;
  assign busSize  = bus_size_q;
  assign busErr   = bus_err_q;
  assign iValid   = i_valid_q;
  assign iRdata   = i_rdata_q;
  assign dValid   = d_valid_q;
  assign dRdata   = d_rdata_q;

endmodule
